// File: rtl/elevator_pkg.sv
// elevator_pkg
// Shared definitions for the elevator call scheduler and the car controller:
// scheduler FSM states, direction encoding and default floor-count parameters.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS_DEF = 4;
  localparam int unsigned FLOOR_W_DEF    = 2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SELECT = 2'b01,
    ST_SERVE  = 2'b10
  } state_e;

endpackage

// File: rtl/elevator_call_picker.sv
// elevator_call_picker
// Combinational SCAN search over a pending-call vector.
//   pending_i    : candidate floors
//   car_floor_i  : car's current floor
//   dir_i        : current direction (DIR_UP / DIR_DOWN)
//   next_floor_o : chosen floor (0 when nothing found)
//   found_o      : a floor was chosen
//   next_dir_o   : direction after the choice (flipped when the search reverses)
// STRICT=0: nearest pending floor at or beyond the car in dir_i, else reverse
//           and take the nearest floor behind the car.
// STRICT=1: nearest pending floor strictly beyond the car in dir_i, never
//           reverses (used for en-route pickup with a pre-masked vector).
module elevator_call_picker
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int unsigned FLOOR_W    = FLOOR_W_DEF,
  parameter bit          STRICT     = 1'b0
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    car_floor_i,
  input  logic                  dir_i,
  output logic [FLOOR_W-1:0]    next_floor_o,
  output logic                  found_o,
  output logic                  next_dir_o
);

  int unsigned          cf;
  int unsigned          idx;
  logic                 hit;
  logic [FLOOR_W-1:0]   fl;
  logic                 nd;

  always_comb begin
    cf  = 32'(car_floor_i);
    idx = 0;
    hit = 1'b0;
    fl  = '0;
    nd  = dir_i;
    if (dir_i == DIR_UP) begin
      // Ascending scan: first hit is the lowest floor ahead.
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
        if (!hit && pending_i[i] && (STRICT ? (i > cf) : (i >= cf))) begin
          hit = 1'b1;
          fl  = FLOOR_W'(i);
        end
      end
      if (!STRICT && !hit) begin
        // Reverse: highest floor below the car.
        for (int unsigned k = 0; k < NUM_FLOORS; k++) begin
          idx = NUM_FLOORS - 1 - k;
          if (!hit && pending_i[idx] && (idx < cf)) begin
            hit = 1'b1;
            fl  = FLOOR_W'(idx);
            nd  = DIR_DOWN;
          end
        end
      end
    end else begin
      // Descending scan: first hit is the highest floor ahead.
      for (int unsigned k = 0; k < NUM_FLOORS; k++) begin
        idx = NUM_FLOORS - 1 - k;
        if (!hit && pending_i[idx] && (STRICT ? (idx < cf) : (idx <= cf))) begin
          hit = 1'b1;
          fl  = FLOOR_W'(idx);
        end
      end
      if (!STRICT && !hit) begin
        // Reverse: lowest floor above the car.
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
          if (!hit && pending_i[i] && (i > cf)) begin
            hit = 1'b1;
            fl  = FLOOR_W'(i);
            nd  = DIR_UP;
          end
        end
      end
    end
    next_floor_o = fl;
    found_o      = hit;
    next_dir_o   = nd;
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
// Latches floor calls and drives the car's next target using SCAN.
//   clk, rst     : clock, asynchronous active-high reset
//   call_btn     : per-floor call buttons (level or pulse)
//   car_floor    : car's current floor
//   car_arrived  : one-cycle pulse, car stopped at car_floor
//   target_floor : floor the car must go to
//   target_valid : target_floor is meaningful (FSM in SERVE)
//   dir_up       : serving upward and not already at the target
//   dir_down     : serving downward and not already at the target
//   pending      : latched unserved calls
//   busy         : FSM not idle
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int unsigned FLOOR_W    = FLOOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_arrived,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  state_e                 state_q, state_d;
  logic [NUM_FLOORS-1:0]  pending_q, pending_d;
  logic [FLOOR_W-1:0]     target_q, target_d;
  logic                   dir_q, dir_d;

  logic [NUM_FLOORS-1:0]  clr_vec;
  logic [NUM_FLOORS-1:0]  ahead_mask;
  logic [NUM_FLOORS-1:0]  pick_pending;

  logic [FLOOR_W-1:0]     sel_floor, pick_floor;
  logic                   sel_found, pick_found;
  logic                   sel_dir, pick_dir;
  logic                   at_target;

  // Arrival clears the car's floor; out-of-range car_floor matches no bit.
  // Clear is applied after set so an open door absorbs a same-edge press.
  always_comb begin
    clr_vec = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      clr_vec[i] = car_arrived && (32'(car_floor) == i);
    end
    pending_d = (pending_q | call_btn) & ~clr_vec;
  end

  // Pickup candidates are the pending floors on the car's side of the target.
  always_comb begin
    ahead_mask = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      ahead_mask[i] = (dir_q == DIR_UP) ? (i < 32'(target_q)) : (i > 32'(target_q));
    end
  end

  assign pick_pending = pending_q & ahead_mask;

  elevator_call_picker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W),
    .STRICT     (1'b0)
  ) u_select (
    .pending_i    (pending_q),
    .car_floor_i  (car_floor),
    .dir_i        (dir_q),
    .next_floor_o (sel_floor),
    .found_o      (sel_found),
    .next_dir_o   (sel_dir)
  );

  elevator_call_picker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W),
    .STRICT     (1'b1)
  ) u_pickup (
    .pending_i    (pick_pending),
    .car_floor_i  (car_floor),
    .dir_i        (dir_q),
    .next_floor_o (pick_floor),
    .found_o      (pick_found),
    .next_dir_o   (pick_dir)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_d    = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        // The non-strict search finds a floor whenever any call is pending.
        if (!sel_found) begin
          state_d = ST_IDLE;
        end else begin
          target_d = sel_floor;
          dir_d    = sel_dir;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (car_arrived && (car_floor == target_q)) begin
          state_d = ST_IDLE;
        end else if (!pending_q[target_q]) begin
          state_d = ST_SELECT;
        end else if (pick_found && (pick_dir == dir_q)) begin
          // Strict mode never reverses, so pick_dir always agrees with dir_q.
          target_d = pick_floor;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      target_q  <= '0;
      dir_q     <= DIR_UP;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
    end
  end

  assign at_target    = (target_q == car_floor);
  assign target_valid = (state_q == ST_SERVE);
  assign target_floor = target_q;
  assign dir_up       = target_valid & (dir_q == DIR_UP) & ~at_target;
  assign dir_down     = target_valid & (dir_q == DIR_DOWN) & ~at_target;
  assign pending      = pending_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
module tb_elevator_call_scheduler;

  localparam int NF = 4;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] call_btn;
  logic [FW-1:0] car_floor;
  logic          car_arrived;
  logic [FW-1:0] target_floor;
  logic          target_valid;
  logic          dir_up;
  logic          dir_down;
  logic [NF-1:0] pending;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  elevator_call_scheduler #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .call_btn     (call_btn),
    .car_floor    (car_floor),
    .car_arrived  (car_arrived),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .dir_up       (dir_up),
    .dir_down     (dir_down),
    .pending      (pending),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: calls as a set of floors, scheduler phase, target, direction.
  localparam int M_WAIT  = 0;
  localparam int M_PICK  = 1;
  localparam int M_SERVE = 2;

  bit mp [NF];
  int m_mode;
  int m_tgt;
  bit m_dir;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic bit any_call();
    for (int f = 0; f < NF; f++) if (mp[f]) return 1'b1;
    return 1'b0;
  endfunction

  // Nearest call ahead in the current direction (car floor counts as ahead);
  // otherwise nearest call anywhere, with the direction reversed.
  function automatic void scan(input int cf, input bit d, output int fl, output bit nd);
    int best;
    best = -1;
    for (int f = 0; f < NF; f++)
      if (mp[f] && (d ? (f >= cf) : (f <= cf)) &&
          (best < 0 || absdiff(f, cf) < absdiff(best, cf))) best = f;
    if (best >= 0) begin
      fl = best; nd = d;
      return;
    end
    for (int f = 0; f < NF; f++)
      if (mp[f] && (best < 0 || absdiff(f, cf) < absdiff(best, cf))) best = f;
    fl = best; nd = ~d;
  endfunction

  task automatic model_reset();
    for (int f = 0; f < NF; f++) mp[f] = 1'b0;
    m_mode = M_WAIT;
    m_tgt  = 0;
    m_dir  = 1'b1;
  endtask

  task automatic model_edge(input logic [NF-1:0] call, input bit arr, input int cf);
    bit np [NF];
    int fl;
    bit nd;
    int best;
    for (int f = 0; f < NF; f++) np[f] = (mp[f] | call[f]) & ~(arr && cf == f);
    case (m_mode)
      M_WAIT: if (any_call()) m_mode = M_PICK;
      M_PICK: begin
        if (!any_call()) m_mode = M_WAIT;
        else begin
          scan(cf, m_dir, fl, nd);
          m_tgt = fl; m_dir = nd; m_mode = M_SERVE;
        end
      end
      default: begin
        if (arr && cf == m_tgt) m_mode = M_WAIT;
        else if (!mp[m_tgt]) m_mode = M_PICK;
        else begin
          best = -1;
          for (int f = 0; f < NF; f++)
            if (mp[f] && (m_dir ? (f > cf && f < m_tgt) : (f < cf && f > m_tgt)) &&
                (best < 0 || absdiff(f, cf) < absdiff(best, cf))) best = f;
          if (best >= 0) m_tgt = best;
        end
      end
    endcase
    mp = np;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NF-1:0] pv;
    bit tv;
    for (int f = 0; f < NF; f++) pv[f] = mp[f];
    tv = (m_mode == M_SERVE);
    check({tag, "_pending"}, 32'(pending), 32'(pv));
    check({tag, "_valid"},   32'(target_valid), 32'(tv));
    check({tag, "_target"},  32'(target_floor), 32'(m_tgt));
    check({tag, "_busy"},    32'(busy), 32'(m_mode != M_WAIT));
    check({tag, "_dir_up"},  32'(dir_up), 32'(tv && m_dir && (m_tgt != int'(car_floor))));
    check({tag, "_dir_dn"},  32'(dir_down), 32'(tv && !m_dir && (m_tgt != int'(car_floor))));
  endtask

  task automatic step(input logic [NF-1:0] call, input bit arr, input int cf, input string tag);
    @(negedge clk);
    call_btn    = call;
    car_arrived = arr;
    car_floor   = FW'(cf);
    model_edge(call, arr, cf);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    int cf;
    logic [NF-1:0] c;
    bit a;

    rst = 1'b1; call_btn = '0; car_floor = '0; car_arrived = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_target", 32'(target_floor), 32'd0);
    check("rst_valid", 32'(target_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dirs", 32'({dir_up, dir_down}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single call to floor 2 from floor 0.
    step(4'b0100, 1'b0, 0, "t1a");
    check("t1_pending", 32'(pending), 32'h4);
    check("t1_valid_n1", 32'(target_valid), 32'd0);
    step(4'b0000, 1'b0, 0, "t1b");
    check("t1_valid_n2", 32'(target_valid), 32'd0);
    step(4'b0000, 1'b0, 0, "t1c");
    check("t1_valid", 32'(target_valid), 32'd1);
    check("t1_target", 32'(target_floor), 32'd2);
    check("t1_dir_up", 32'(dir_up), 32'd1);
    step(4'b0000, 1'b1, 2, "t1d");
    check("t1_arr_pending", 32'(pending), 32'd0);
    check("t1_arr_valid", 32'(target_valid), 32'd0);
    check("t1_arr_busy", 32'(busy), 32'd0);

    // SCAN order: car at 1 going up, calls at 0 and 3.
    step(4'b1001, 1'b0, 1, "t2a");
    step(4'b0000, 1'b0, 1, "t2b");
    step(4'b0000, 1'b0, 1, "t2c");
    check("t2_first", 32'(target_floor), 32'd3);
    step(4'b0000, 1'b1, 3, "t2d");
    check("t2_left", 32'(pending), 32'h1);
    step(4'b0000, 1'b0, 3, "t2e");
    step(4'b0000, 1'b0, 3, "t2f");
    check("t2_second", 32'(target_floor), 32'd0);
    check("t2_dir_dn", 32'(dir_down), 32'd1);
    step(4'b0000, 1'b1, 0, "t2g");

    // En-route pickup: heading to 3 from 1, call at 2 appears.
    step(4'b1000, 1'b0, 1, "t3a");
    step(4'b0000, 1'b0, 1, "t3b");
    step(4'b0000, 1'b0, 1, "t3c");
    check("t3_to3", 32'(target_floor), 32'd3);
    step(4'b0100, 1'b0, 1, "t3d");
    check("t3_hold", 32'(target_floor), 32'd3);
    check("t3_valid1", 32'(target_valid), 32'd1);
    step(4'b0000, 1'b0, 1, "t3e");
    check("t3_pick", 32'(target_floor), 32'd2);
    check("t3_valid2", 32'(target_valid), 32'd1);
    step(4'b0000, 1'b1, 2, "t3f");
    step(4'b0000, 1'b0, 2, "t3g");
    step(4'b0000, 1'b0, 2, "t3h");
    step(4'b0000, 1'b1, 3, "t3i");

    // Same-edge set and clear at floor 1.
    step(4'b0010, 1'b1, 1, "t4");
    check("t4_pending", 32'(pending), 32'd0);

    // Call at the current floor.
    step(4'b0100, 1'b0, 2, "t5a");
    step(4'b0000, 1'b0, 2, "t5b");
    step(4'b0000, 1'b0, 2, "t5c");
    check("t5_target", 32'(target_floor), 32'd2);
    check("t5_valid", 32'(target_valid), 32'd1);
    check("t5_dirs", 32'({dir_up, dir_down}), 32'd0);
    step(4'b0000, 1'b1, 2, "t5d");

    // Asynchronous reset while serving.
    step(4'b1000, 1'b0, 0, "t6a");
    step(4'b0010, 1'b0, 0, "t6b");
    step(4'b0000, 1'b0, 0, "t6c");
    check("t6_serving", 32'(target_valid), 32'd1);
    @(negedge clk);
    call_btn = '0;
    #1 rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(target_valid), 32'd0);
    check("t6_async_pending", 32'(pending), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_dirs", 32'({dir_up, dir_down}), 32'd0);
    check("t6_async_target", 32'(target_floor), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b0000, 1'b0, 0, "t6d");
    step(4'b0000, 1'b0, 0, "t6e");
    check("t6_idle", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    cf = 0;
    for (int n = 0; n < 400; n++) begin
      c = ($urandom_range(0, 3) == 0) ? NF'($urandom) : '0;
      a = 1'b0;
      if (m_mode == M_SERVE && $urandom_range(0, 2) == 0)
        cf = cf + ((m_tgt > cf) ? 1 : ((m_tgt < cf) ? -1 : 0));
      if (m_mode == M_SERVE && cf == m_tgt && $urandom_range(0, 1) == 1) a = 1'b1;
      else if ($urandom_range(0, 19) == 0) begin
        a  = 1'b1;
        cf = int'($urandom_range(0, NF - 1));
      end
      step(c, a, cf, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Collects floor call buttons for the elevator car, latches them as pending calls, and decides which floor the car serves next using a SCAN policy: keep the current direction while calls lie ahead, reverse otherwise. It sits between the button inputs and the car controller. It drives the car's floor request with a valid/arrived handshake and retires each call when the car reports arrival at that floor.

## Interface
- NUM_FLOORS, 4, number of floors (2..16)
- FLOOR_W, 2, floor index width, $clog2(NUM_FLOORS)

- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- call_btn  input  NUM_FLOORS  per-floor call request, sampled every edge; level or pulse
- car_floor  input  FLOOR_W  car's current floor
- car_arrived  input  1  one-cycle pulse: car stopped at car_floor with the door opening
- target_floor  output  FLOOR_W  floor the car must go to
- target_valid  output  1  target_floor is meaningful and stable
- dir_up  output  1  scheduler serving upward
- dir_down  output  1  scheduler serving downward
- pending  output  NUM_FLOORS  latched unserved calls
- busy  output  1  FSM not in IDLE

## Operation
- Pending register:
  - pending[i] is set on an edge where call_btn[i]=1.
  - pending[i] is cleared on an edge where car_arrived=1 and car_floor==i, whether or not i is the target.
  - If set and clear hit the same floor on the same edge, clear wins: the call is served by the open door.
- Direction register dir (1 = up) resets to up.
- SCAN selection, combinational, from pending, car_floor and dir:
  - Up: lowest pending floor ≥ car_floor.
  - If none, flip to down and take the highest pending floor < car_floor.
  - Down is symmetric: highest pending floor ≤ car_floor, else flip and take the lowest pending floor > car_floor.
  - found=0 when pending==0.
- FSM states:
  - IDLE: target_valid=0. If pending≠0, go to SELECT.
  - SELECT: one cycle. Register target_floor and dir from the selection, then go to SERVE. If pending has become 0, return to IDLE.
  - SERVE: target_valid=1.
    - On car_arrived with car_floor==target_floor, go to IDLE. The pending bit clears on the same edge.
    - En-route pickup: while in SERVE, if a pending floor lies strictly between car_floor and target_floor in the current dir, target_floor moves to the nearest such floor on the next edge. target_valid stays 1.
    - If pending[target_floor] clears while car_arrived is not on the target, go to SELECT. This is not reachable in normal use; it is a defensive path.
  - Illegal state encoding: go to IDLE.
- Outputs:
  - dir_up = target_valid & dir.
  - dir_down = target_valid & ~dir.
  - If target_floor==car_floor, dir_up and dir_down are both 0.
- A call_btn at car_floor while IDLE is selected normally, and the car opens its door in place.
- Buttons with index ≥ NUM_FLOORS do not exist. A car_floor value ≥ NUM_FLOORS is ignored for clearing.

## Timing
- Reset values: target_floor=0, target_valid=0, dir_up=0, dir_down=0, pending=0, busy=0. State is IDLE, dir is up.
- Reset mid-SERVE drops every pending call and deasserts target_valid asynchronously.
- Call latency: call_btn high at edge N gives pending[i]=1 after N, SELECT after N+1, and target_valid=1 after N+2.
- Arrival: car_arrived at edge M gives target_valid=0 and pending[target] cleared after M. The next SELECT comes at M+1 if other calls remain.
- Retarget latency: one edge after the qualifying pending bit is set.
- target_floor changes only in SELECT, or in SERVE through the en-route pickup. It is otherwise stable while target_valid=1.

## Structure
- Shared package elevator_pkg:
  - state enum (IDLE, SELECT, SERVE)
  - DIR_UP/DIR_DOWN constants
  - default NUM_FLOORS and FLOOR_W
  - The car controller reuses the package.
- Sub-module elevator_call_picker: purely combinational SCAN search (pending, car_floor, dir → next_floor, found, next_dir). It is instantiated twice: once for selection and once, in strict-between mode, for en-route pickup.

## Test plan
- Single call: reset, car_floor=0, pulse call_btn[2] → pending=0100; target_valid=1 with target_floor=2 and dir_up=1 two edges later; car_arrived at floor 2 → pending=0, target_valid=0, busy=0.
- SCAN order: car_floor=1, dir up, pending {0,3} → target 3 first; after arrival at 3 → target 0 with dir_down=1.
- En-route pickup: in SERVE toward 3 with car_floor=1, press call_btn[2] → target_floor=2 one edge later, target_valid never drops.
- Same-edge set/clear: car_arrived at floor 1 while call_btn[1]=1 → pending[1]=0 after the edge.
- Call at current floor: IDLE, car_floor=2, call_btn[2] → target_floor=2, dir_up=dir_down=0.
- Reset mid-SERVE: assert rst between clock edges → all outputs 0 immediately; after release, FSM stays in IDLE with no calls.
